// File: rtl/ifetch_queue_pkg.sv
// Shared widths and slot layout for the instruction prefetch queue.
package ifetch_queue_pkg;

    localparam int unsigned       ADDR_W  = 64;
    localparam int unsigned       INSTR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue_slot_ram.sv
// Slot storage: reserve port writes the PC, fill port writes the instruction, one read port.
module ifetch_queue_slot_ram
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_clear,
    input  logic               i_rsv_en,
    input  logic [PW-1:0]      i_rsv_idx,
    input  logic [ADDR_W-1:0]  i_rsv_pc,
    input  logic               i_fill_en,
    input  logic [PW-1:0]      i_fill_idx,
    input  logic [INSTR_W-1:0] i_fill_instr,
    input  logic               i_pop_en,
    input  logic [PW-1:0]      i_pop_idx,
    input  logic [PW-1:0]      i_rd_idx,
    output ifq_entry_t         o_rd_entry
);

    ifq_entry_t r_slots [DEPTH];
    ifq_entry_t w_rsv_entry;

    always_comb begin
        w_rsv_entry        = '0;
        w_rsv_entry.pc     = i_rsv_pc;
        w_rsv_entry.filled = 1'b0;
    end

    // Reserve, fill and pop never target the same slot in one cycle.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            if (i_rsv_en) begin
                r_slots[i_rsv_idx] <= w_rsv_entry;
            end
            if (i_fill_en) begin
                r_slots[i_fill_idx].instr  <= i_fill_instr;
                r_slots[i_fill_idx].filled <= 1'b1;
            end
            if (i_pop_en) begin
                r_slots[i_pop_idx].filled <= 1'b0;
            end
        end
    end

    assign o_rd_entry = r_slots[i_rd_idx];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: in-order imem requests, slot reservation, redirect flush with
// drop accounting for responses still in flight.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
    localparam int unsigned      PW       = $clog2(DEPTH),
    localparam int unsigned      CW       = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_redirect_valid,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_gnt,
    input  logic               i_imem_rsp_valid,
    input  logic [INSTR_W-1:0] i_imem_rsp_data,
    output logic               o_out_valid,
    output logic [ADDR_W-1:0]  o_out_pc,
    output logic [INSTR_W-1:0] o_out_instr,
    input  logic               i_out_ready,
    output logic [CW-1:0]      o_count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [PW-1:0]      r_wr_ptr, r_fill_ptr, r_rd_ptr;
    logic [CW-1:0]      r_count, r_outst, r_drop;
    logic [ADDR_W-1:0]  r_hold_pc;
    logic [INSTR_W-1:0] r_hold_instr;

    ifq_entry_t w_head;
    logic       w_req, w_grant, w_pop, w_rsp_drop, w_rsp_fill, w_clear;

    always_comb begin
        w_req       = !i_reset && !i_redirect_valid && (r_count < FULL);
        w_grant     = w_req && i_imem_gnt;
        o_out_valid = w_head.filled && !i_redirect_valid && !i_reset;
        w_pop       = o_out_valid && i_out_ready;
        w_rsp_drop  = i_imem_rsp_valid && (r_drop != '0);
        w_rsp_fill  = i_imem_rsp_valid && (r_drop == '0) && !i_redirect_valid && !i_reset;
        w_clear     = i_reset || i_redirect_valid;
    end

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_fetch_pc;
    assign o_count     = r_count;
    // Outputs come from registered slots only; hold the last head when nothing is filled.
    assign o_out_pc    = w_head.filled ? w_head.pc : r_hold_pc;
    assign o_out_instr = w_head.filled ? w_head.instr : r_hold_instr;

    ifetch_queue_slot_ram #(
        .DEPTH (DEPTH)
    ) u_slot_ram (
        .i_clk        (i_clk),
        .i_clear      (w_clear),
        .i_rsv_en     (w_grant),
        .i_rsv_idx    (r_wr_ptr),
        .i_rsv_pc     (r_fetch_pc),
        .i_fill_en    (w_rsp_fill),
        .i_fill_idx   (r_fill_ptr),
        .i_fill_instr (i_imem_rsp_data),
        .i_pop_en     (w_pop),
        .i_pop_idx    (r_rd_ptr),
        .i_rd_idx     (r_rd_ptr),
        .o_rd_entry   (w_head)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_outst    <= '0;
            r_drop     <= '0;
        end else if (i_redirect_valid) begin
            // Everything still owed by memory becomes a drop, less any response landing now.
            r_fetch_pc <= i_redirect_pc;
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_outst    <= '0;
            r_drop     <= r_drop + r_outst - CW'(i_imem_rsp_valid);
        end else begin
            if (w_grant) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            if (w_rsp_fill) begin
                r_fill_ptr <= r_fill_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_rsp_drop) begin
                r_drop <= r_drop - 1'b1;
            end
            r_count <= r_count + CW'(w_grant) - CW'(w_pop);
            r_outst <= r_outst + CW'(w_grant) - CW'(w_rsp_fill);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
        end else if (w_head.filled) begin
            r_hold_pc    <= w_head.pc;
            r_hold_instr <= w_head.instr;
        end
    end

    a_rsp_expected: assert property (@(posedge i_clk) disable iff (i_reset)
        i_imem_rsp_valid |-> (r_drop != '0 || r_outst != '0));
    a_drop_bound: assert property (@(posedge i_clk) disable iff (i_reset) r_drop <= FULL);
    a_fill_behind_wr: assert property (@(posedge i_clk) disable iff (i_reset) r_outst <= r_count);

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus randomized traffic against a queue-level model.
module tb_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        bit          filled;
    } ent_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1, redirect_valid = 1'b0, imem_gnt = 1'b0, out_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req, out_valid;
    logic [63:0] imem_addr, out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int chk = 0, err = 0, cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
    ent_t        mq[$];
    mreq_t       mem_q[$];
    logic [63:0] mpc = RESET_PC;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_gnt       (imem_gnt),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .o_out_valid      (out_valid),
        .o_out_pc         (out_pc),
        .o_out_instr      (out_instr),
        .i_out_ready      (out_ready),
        .o_count          (count)
    );

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'hC0DE_5A17;
    endfunction

    function automatic bit m_req();
        return !reset && !redirect_valid && (mq.size() < int'(DEPTH));
    endfunction

    function automatic bit m_ov();
        return !reset && !redirect_valid && (mq.size() > 0) && mq[0].filled;
    endfunction

    // Reference queue: reserved entries in program order, memory requests tagged stale on flush.
    task automatic model_update();
        bit    g, p, done;
        int    due;
        mreq_t m;
        g = m_req() && imem_gnt;
        p = m_ov() && out_ready;
        if (reset) begin
            mq.delete();
            mem_q.delete();
            mpc = RESET_PC;
            last_due = 0;
        end else begin
            if (rsp_valid) begin
                m = mem_q.pop_front();
                if (!redirect_valid && !m.stale) begin
                    done = 1'b0;
                    foreach (mq[i]) begin
                        if (!done && !mq[i].filled) begin
                            mq[i].filled = 1'b1;
                            mq[i].instr  = rsp_data;
                            done = 1'b1;
                        end
                    end
                end
            end
            if (redirect_valid) begin
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                mq.delete();
                mpc = redirect_pc;
            end else begin
                if (p) void'(mq.pop_front());
                if (g) begin
                    mq.push_back('{pc: mpc, instr: 32'h0, filled: 1'b0});
                    due = cyc + int'($urandom_range(lat_max, lat_min));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    mem_q.push_back('{addr: mpc, due: due, stale: 1'b0});
                    mpc = mpc + 64'd4;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        rsp_valid = 1'b0;
        rsp_data  = $urandom;
        if (mem_q.size() > 0) begin
            if (mem_q[0].due <= cyc) begin
                rsp_valid = 1'b1;
                rsp_data  = mem_data(mem_q[0].addr);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        imem_gnt = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        tick();
        @(negedge clk);
        chk++;
        if (imem_req !== 1'b0 || count !== 3'd0) begin
            err++;
            $display("FAIL reset_hold: req=%b count=%0d, expected req=0 count=0", imem_req, count);
        end
        tick();
        reset = 1'b0;
        imem_gnt = 1'b0;
        @(negedge clk);
        chk++;
        if (out_valid !== 1'b0 || count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            err++;
            $display("FAIL reset_state: ov=%b count=%0d req=%b addr=%h, expected 0/0/1/%h",
                     out_valid, count, imem_req, imem_addr, RESET_PC);
        end
        tick();
    endtask

    task automatic test_stream();
        logic [63:0] epc;
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 10; i++) begin
            imem_gnt = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            chk++;
            if (imem_addr !== 64'(4 * i) || out_valid !== (i >= 2)) begin
                err++;
                $display("FAIL stream_c%0d: addr=%h ov=%b, expected addr=%h ov=%b",
                         i, imem_addr, out_valid, 64'(4 * i), (i >= 2));
            end
            if (i >= 2) begin
                epc = 64'(4 * (i - 2));
                chk++;
                if (out_pc !== epc || out_instr !== mem_data(epc)) begin
                    err++;
                    $display("FAIL stream_out%0d: pc=%h instr=%h, expected pc=%h instr=%h",
                             i, out_pc, out_instr, epc, mem_data(epc));
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 6; i++) begin
            imem_gnt = 1'b1;
            out_ready = 1'b0;
            @(negedge clk);
            chk++;
            if (imem_req !== (i < 4) || count !== 3'((i < 4) ? i : 4) || out_valid !== (i >= 2)) begin
                err++;
                $display("FAIL stall_c%0d: req=%b count=%0d ov=%b, expected req=%b count=%0d ov=%b",
                         i, imem_req, count, out_valid, (i < 4), ((i < 4) ? i : 4), (i >= 2));
            end
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            out_ready = 1'b1;
            @(negedge clk);
            chk++;
            if (out_valid !== 1'b1 || out_pc !== 64'(4 * j)) begin
                err++;
                $display("FAIL stall_drain%0d: ov=%b pc=%h, expected ov=1 pc=%h",
                         j, out_valid, out_pc, 64'(4 * j));
            end
            tick();
        end
    endtask

    task automatic test_redirect_drop();
        bit found = 1'b0;
        do_reset();
        lat_min = 3;
        lat_max = 3;
        out_ready = 1'b1;
        imem_gnt = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        imem_gnt = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h100;
        @(negedge clk);
        chk++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            err++;
            $display("FAIL drop_redirect_cycle: req=%b ov=%b, expected 0/0", imem_req, out_valid);
        end
        tick();
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        @(negedge clk);
        chk++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin
            err++;
            $display("FAIL drop_refetch: req=%b addr=%h, expected req=1 addr=100", imem_req, imem_addr);
        end
        tick();
        imem_gnt = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                found = 1'b1;
                chk++;
                if (out_pc !== 64'h100 || out_instr !== mem_data(64'h100)) begin
                    err++;
                    $display("FAIL drop_first_out: pc=%h instr=%h, expected pc=100 instr=%h",
                             out_pc, out_instr, mem_data(64'h100));
                end
            end
            tick();
        end
        if (!found) begin
            chk++;
            err++;
            $display("FAIL drop_timeout: out_valid=0 after 12 cycles, expected 1");
        end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 4; i++) begin
            imem_gnt = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        chk++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
            err++;
            $display("FAIL pop_squash: ov=%b req=%b, expected 0/0", out_valid, imem_req);
        end
        tick();
        redirect_valid = 1'b0;
        imem_gnt = 1'b0;
        @(negedge clk);
        chk++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imem_req !== 1'b1
            || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            err++;
            $display("FAIL pop_after: count=%0d ov=%b req=%b addr=%h, expected 0/0/1/fffffffffffffffc",
                     count, out_valid, imem_req, imem_addr);
        end
        tick();
        imem_gnt = 1'b1;
        @(negedge clk);
        tick();
        imem_gnt = 1'b0;
        @(negedge clk);
        chk++;
        if (imem_addr !== 64'h0 || count !== 3'd1) begin
            err++;
            $display("FAIL pc_wrap: addr=%h count=%0d, expected addr=0 count=1", imem_addr, count);
        end
        tick();
    endtask

    task automatic test_gnt_hold();
        do_reset();
        lat_min = 1;
        lat_max = 1;
        out_ready = 1'b1;
        imem_gnt = 1'b1;
        @(negedge clk);
        tick();
        for (int i = 0; i < 4; i++) begin
            imem_gnt = (i == 3);
            @(negedge clk);
            chk++;
            if (imem_req !== 1'b1 || imem_addr !== 64'h4) begin
                err++;
                $display("FAIL gnt_hold%0d: req=%b addr=%h, expected req=1 addr=4", i, imem_req, imem_addr);
            end
            tick();
        end
        imem_gnt = 1'b0;
        @(negedge clk);
        chk++;
        if (imem_addr !== 64'h8) begin
            err++;
            $display("FAIL gnt_advance: addr=%h, expected 8", imem_addr);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat_min = 1;
        lat_max = 1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_gnt = 1'b1;
            @(negedge clk);
            tick();
        end
        imem_gnt = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk++;
        if (count !== 3'd3) begin
            err++;
            $display("FAIL mid_precount: count=%0d, expected 3", count);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk++;
        if (out_valid !== 1'b0 || count !== 3'd0 || imem_addr !== RESET_PC || imem_req !== 1'b1) begin
            err++;
            $display("FAIL mid_reset: ov=%b count=%0d addr=%h req=%b, expected 0/0/%h/1",
                     out_valid, count, imem_addr, imem_req, RESET_PC);
        end
        tick();
    endtask

    task automatic test_random();
        bit e_req, e_ov;
        do_reset();
        lat_min = 1;
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(299, 0) == 0);
            redirect_valid = ($urandom_range(15, 0) == 0);
            redirect_pc    = {$urandom, $urandom} & ~64'h3;
            imem_gnt       = ($urandom_range(3, 0) != 0);
            out_ready      = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            if (!reset) begin
                e_req = m_req();
                e_ov  = m_ov();
                chk++;
                if (imem_req !== e_req || imem_addr !== mpc || out_valid !== e_ov
                    || count !== 3'(mq.size())) begin
                    err++;
                    $display("FAIL rand_ctl@%0d: req=%b addr=%h ov=%b count=%0d, expected %b/%h/%b/%0d",
                             cyc, imem_req, imem_addr, out_valid, count, e_req, mpc, e_ov, mq.size());
                end
                if (e_ov) begin
                    chk++;
                    if (out_pc !== mq[0].pc || out_instr !== mq[0].instr) begin
                        err++;
                        $display("FAIL rand_out@%0d: pc=%h instr=%h, expected pc=%h instr=%h",
                                 cyc, out_pc, out_instr, mq[0].pc, mq[0].instr);
                    end
                end
            end
            tick();
        end
        reset = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_pop();
        test_gnt_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
